// File: rtl/audio_i2s_tx.sv
// I2S serializer in the audio_mclk domain: divides MCLK into SCLK, frames L/R slots on LRCK, shifts MSB-first data.
// Define AUDIO_MONO_MIX_EN to send the floor-average of L and R in both slots instead of stereo pass-through.
module audio_i2s_tx #(
    parameter int unsigned SCLK_DIV  = 4,
    parameter int unsigned SLOT_BITS = 32,
    parameter int unsigned DATA_W    = 16
) (
    input  logic              audio_mclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] audio_l,
    input  logic [DATA_W-1:0] audio_r,
    output logic              audio_sclk,
    output logic              audio_lrck,
    output logic              audio_dac,
    output logic              sample_req
);

    localparam int unsigned MW = (SCLK_DIV > 2) ? $clog2(SCLK_DIV) : 1;
    localparam int unsigned BW = $clog2(2 * SLOT_BITS);

    logic [MW-1:0]     mclk_cnt;
    logic [MW-1:0]     mclk_nxt;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_nxt;
    logic [BW-1:0]     pos_nxt;
    logic              fall;
    logic              frame_start;
    logic              lrck_nxt;
    logic              dac_nxt;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] latch_l;
    logic [DATA_W-1:0] latch_r;
    logic [DATA_W-1:0] cur;

`ifdef AUDIO_MONO_MIX_EN
    logic signed [DATA_W:0] mix_sum;

    always_comb begin
        mix_sum = $signed({audio_l[DATA_W-1], audio_l}) + $signed({audio_r[DATA_W-1], audio_r});
        latch_l = DATA_W'(mix_sum >>> 1);
        latch_r = latch_l;
    end
`else
    always_comb begin
        latch_l = audio_l;
        latch_r = audio_r;
    end
`endif

    always_comb begin
        fall        = (mclk_cnt == MW'(SCLK_DIV - 1));
        mclk_nxt    = fall ? '0 : mclk_cnt + 1'b1;
        bit_nxt     = (bit_cnt == BW'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + 1'b1;
        frame_start = fall && (bit_nxt == '0);
        lrck_nxt    = (bit_nxt >= BW'(SLOT_BITS));
        pos_nxt     = lrck_nxt ? bit_nxt - BW'(SLOT_BITS) : bit_nxt;
        // At frame start pos_nxt is 0, so reading the old hold registers here is safe.
        cur         = lrck_nxt ? hold_r : hold_l;
        dac_nxt     = 1'b0;
        for (int unsigned i = 1; i <= DATA_W; i++) begin
            if (pos_nxt == BW'(i)) begin
                dac_nxt = cur[DATA_W - i];
            end
        end
    end

    always_ff @(posedge audio_mclk or posedge reset) begin
        if (reset) begin
            mclk_cnt   <= '0;
            bit_cnt    <= BW'(2 * SLOT_BITS - 1);
            audio_sclk <= 1'b0;
            audio_lrck <= 1'b1;
            audio_dac  <= 1'b0;
            sample_req <= 1'b0;
            hold_l     <= '0;
            hold_r     <= '0;
        end else begin
            mclk_cnt   <= mclk_nxt;
            audio_sclk <= (mclk_nxt >= MW'(SCLK_DIV / 2));
            sample_req <= frame_start;
            if (fall) begin
                bit_cnt    <= bit_nxt;
                audio_lrck <= lrck_nxt;
                audio_dac  <= dac_nxt;
            end
            if (frame_start) begin
                hold_l <= latch_l;
                hold_r <= latch_r;
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: scoreboard of latched L/R pairs compared against words decoded from the I2S wire.
module tb_audio_i2s_tx;

    logic        audio_mclk = 1'b0;
    logic        reset;
    logic [15:0] audio_l;
    logic [15:0] audio_r;
    logic        audio_sclk;
    logic        audio_lrck;
    logic        audio_dac;
    logic        sample_req;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] el;
        logic [15:0] er;
        logic [15:0] gl;
        logic [15:0] gr;
        int          pad;
    } frame_t;

    frame_t      results[$];
    logic [31:0] exp_q[$];
    logic [15:0] prev_l;
    logic [15:0] prev_r;
    int          sclk_bad = 0;
    int          align_bad = 0;

    audio_i2s_tx #(.SCLK_DIV(4), .SLOT_BITS(32), .DATA_W(16)) dut (
        .audio_mclk (audio_mclk),
        .reset      (reset),
        .audio_l    (audio_l),
        .audio_r    (audio_r),
        .audio_sclk (audio_sclk),
        .audio_lrck (audio_lrck),
        .audio_dac  (audio_dac),
        .sample_req (sample_req)
    );

    always #5 audio_mclk = ~audio_mclk;

    function automatic logic [15:0] exp_word(input logic [15:0] l, input logic [15:0] r, input logic right);
`ifdef AUDIO_MONO_MIX_EN
        int s;
        s = int'($signed(l)) + int'($signed(r));
        s = s >>> 1;
        return right ? s[15:0] : s[15:0];
`else
        return right ? r : l;
`endif
    endfunction

    // Inputs as seen by the DUT on the most recent active edge.
    initial forever begin
        @(posedge audio_mclk);
        prev_l = audio_l;
        prev_r = audio_r;
    end

    // Wire decoder: sample data on SCLK rise, rebuild slots, pair them with scoreboard entries.
    initial begin
        logic        ps, pl, pd, slot, act, first_run;
        int          p, pad, run;
        logic [31:0] cur;
        logic [15:0] wl, wr;
        ps = 0; pl = 1; pd = 0; slot = 1; act = 0; first_run = 1;
        p = 0; pad = 0; run = 0; cur = '0; wl = '0; wr = '0;
        forever begin
            @(negedge audio_mclk);
            if (reset) begin
                exp_q.delete();
                act = 0; slot = 1; p = 0; pad = 0; run = 0; first_run = 1;
                ps = 0; pl = 1; pd = 0;
            end else begin
                if (sample_req)
                    exp_q.push_back({exp_word(prev_l, prev_r, 1'b0), exp_word(prev_l, prev_r, 1'b1)});
                if (audio_sclk == ps) run++;
                else begin
                    if (!first_run && run != 2) sclk_bad++;
                    first_run = 0;
                    run = 1;
                end
                if ((audio_dac !== pd || audio_lrck !== pl) && !(ps && !audio_sclk)) align_bad++;
                if (audio_sclk && !ps) begin
                    if (audio_lrck != slot) begin
                        slot = audio_lrck;
                        p = 0;
                        if (!slot) begin
                            pad = 0;
                            if (exp_q.size() > 0) begin
                                cur = exp_q.pop_front();
                                act = 1;
                            end else act = 0;
                        end
                    end else p++;
                    if (p == 0 || p > 16) begin
                        if (audio_dac !== 1'b0) pad++;
                    end else if (!slot) wl[16-p] = audio_dac;
                    else wr[16-p] = audio_dac;
                    if (p > 31) pad++;
                    if (slot && p == 31 && act) begin
                        results.push_back('{cur[31:16], cur[15:0], wl, wr, pad});
                        act = 0;
                    end
                end
                ps = audio_sclk; pl = audio_lrck; pd = audio_dac;
            end
        end
    end

    task automatic get_frame(output frame_t f, output bit ok);
        ok = 0;
        f = '{16'h0, 16'h0, 16'h0, 16'h0, 0};
        for (int i = 0; i < 700 && results.size() == 0; i++) @(negedge audio_mclk);
        if (results.size() > 0) begin
            f = results.pop_front();
            ok = 1;
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge audio_mclk);
            if (sample_req) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_startup(input string tag);
        int   first, period;
        logic lr3, lr_at;
        @(negedge audio_mclk);
        #1 reset = 1'b0;
        first = 0; period = 0; lr3 = 1'bx; lr_at = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge audio_mclk);
            if (k == 3) lr3 = audio_lrck;
            if (sample_req) begin
                first = k;
                lr_at = audio_lrck;
                break;
            end
        end
        checks++; if (first !== 4) begin errors++; $display("FAIL %s_first_req: got %0d expected 4", tag, first); end
        checks++; if (lr3 !== 1'b1) begin errors++; $display("FAIL %s_lrck_before: got %b expected 1", tag, lr3); end
        checks++; if (lr_at !== 1'b0) begin errors++; $display("FAIL %s_lrck_at_req: got %b expected 0", tag, lr_at); end
        for (int i = 1; i <= 600; i++) begin
            @(negedge audio_mclk);
            if (sample_req) begin
                period = i;
                break;
            end
        end
        checks++; if (period !== 256) begin errors++; $display("FAIL %s_period: got %0d expected 256", tag, period); end
    endtask

    task automatic test_reset();
        reset = 1'b1; audio_l = '0; audio_r = '0;
        repeat (3) @(negedge audio_mclk);
        checks++; if (audio_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", audio_sclk); end
        checks++; if (audio_lrck !== 1'b1) begin errors++; $display("FAIL rst_lrck: got %b expected 1", audio_lrck); end
        checks++; if (audio_dac !== 1'b0) begin errors++; $display("FAIL rst_dac: got %b expected 0", audio_dac); end
        checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", sample_req); end
        check_startup("start");
    endtask

    task automatic test_patterns();
        logic [15:0] tl[5];
        logic [15:0] tr[5];
        frame_t      f;
        bit          ok;
        tl = '{16'hA5C3, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000};
        tr = '{16'h0F0F, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0000};
        tl[4] = 16'($urandom);
        tr[4] = 16'($urandom);
        for (int n = 0; n < 5; n++) begin
            @(negedge audio_mclk);
            audio_l = tl[n]; audio_r = tr[n];
            results.delete();
            for (int k = 0; k < 2; k++) begin
                get_frame(f, ok);
                checks++;
                if (!ok) begin errors++; $display("FAIL pat%0d_timeout: got none expected frame", n); end
                else begin
                    if (f.gl !== f.el) begin errors++; $display("FAIL pat%0d_left: got %h expected %h", n, f.gl, f.el); end
                    checks++; if (f.gr !== f.er) begin errors++; $display("FAIL pat%0d_right: got %h expected %h", n, f.gr, f.er); end
                    checks++; if (f.pad !== 0) begin errors++; $display("FAIL pat%0d_pad: got %0d expected 0", n, f.pad); end
                    if (k == 1) begin
                        checks++;
                        if (f.gl !== exp_word(tl[n], tr[n], 1'b0)) begin errors++; $display("FAIL pat%0d_left_abs: got %h expected %h", n, f.gl, exp_word(tl[n], tr[n], 1'b0)); end
                        checks++;
                        if (f.gr !== exp_word(tl[n], tr[n], 1'b1)) begin errors++; $display("FAIL pat%0d_right_abs: got %h expected %h", n, f.gr, exp_word(tl[n], tr[n], 1'b1)); end
                    end
                end
            end
        end
    endtask

    task automatic test_midframe();
        frame_t      f;
        bit          ok;
        logic [15:0] e1, e2;
        e1 = exp_word(16'h1234, 16'h0F0F, 1'b0);
        e2 = exp_word(16'hBEEF, 16'h0F0F, 1'b0);
        @(negedge audio_mclk);
        audio_l = 16'h1234; audio_r = 16'h0F0F;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_sync: got none expected sample_req"); end
        results.delete();
        repeat (80) @(negedge audio_mclk);
        audio_l = 16'hBEEF;
        get_frame(f, ok);
        checks++; if (!ok || f.gl !== e1) begin errors++; $display("FAIL mid_current: got %h expected %h", f.gl, e1); end
        checks++; if (f.gl !== f.el || f.gr !== f.er) begin errors++; $display("FAIL mid_current_sb: got %h/%h expected %h/%h", f.gl, f.gr, f.el, f.er); end
        get_frame(f, ok);
        checks++; if (!ok || f.gl !== e2) begin errors++; $display("FAIL mid_next: got %h expected %h", f.gl, e2); end
    endtask

    task automatic test_reset_mid();
        frame_t      f;
        bit          ok;
        logic [15:0] er;
        logic        ebit;
        er = exp_word(16'hBEEF, 16'h0F0F, 1'b1);
        ebit = er[8];
        @(negedge audio_mclk);
        audio_l = 16'hBEEF; audio_r = 16'h0F0F;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rmid_sync: got none expected sample_req"); end
        repeat (162) @(negedge audio_mclk);
        checks++; if (audio_sclk !== 1'b1) begin errors++; $display("FAIL rmid_pre_sclk: got %b expected 1", audio_sclk); end
        checks++; if (audio_lrck !== 1'b1) begin errors++; $display("FAIL rmid_pre_lrck: got %b expected 1", audio_lrck); end
        checks++; if (audio_dac !== ebit) begin errors++; $display("FAIL rmid_pre_dac: got %b expected %b", audio_dac, ebit); end
        #1 reset = 1'b1;
        #1;
        checks++; if (audio_sclk !== 1'b0) begin errors++; $display("FAIL rmid_sclk: got %b expected 0", audio_sclk); end
        checks++; if (audio_lrck !== 1'b1) begin errors++; $display("FAIL rmid_lrck: got %b expected 1", audio_lrck); end
        checks++; if (audio_dac !== 1'b0) begin errors++; $display("FAIL rmid_dac: got %b expected 0", audio_dac); end
        checks++; if (sample_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %b expected 0", sample_req); end
        repeat (3) @(negedge audio_mclk);
        check_startup("restart");
        results.delete();
        get_frame(f, ok);
        get_frame(f, ok);
        checks++; if (!ok || f.gr !== er) begin errors++; $display("FAIL rmid_resume: got %h expected %h", f.gr, er); end
    endtask

    task automatic test_sclk();
        bit         ok;
        logic [7:0] win;
        logic       lr_any;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL sclk_sync: got none expected sample_req"); end
        win = '0;
        lr_any = audio_lrck;
        win[7] = audio_sclk;
        for (int i = 6; i >= 0; i--) begin
            @(negedge audio_mclk);
            win[i] = audio_sclk;
            lr_any = lr_any | audio_lrck;
        end
        checks++; if (win !== 8'b0011_0011) begin errors++; $display("FAIL sclk_shape: got %b expected 00110011", win); end
        checks++; if (lr_any !== 1'b0) begin errors++; $display("FAIL sclk_lrck_left: got %b expected 0", lr_any); end
        checks++; if (sclk_bad !== 0) begin errors++; $display("FAIL sclk_runs: got %0d expected 0", sclk_bad); end
        checks++; if (align_bad !== 0) begin errors++; $display("FAIL edge_align: got %0d expected 0", align_bad); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_patterns();
        test_midframe();
        test_reset_mid();
        test_sclk();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
